// File: rtl/emergency_preempt_pkg.sv
// Shared types for the emergency preemption arbiter: FSM state encoding,
// approach direction codes and the direction-to-one-hot helper.
package emergency_preempt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  localparam logic [1:0] DIR_S1 = 2'd0;
  localparam logic [1:0] DIR_S2 = 2'd1;
  localparam logic [1:0] DIR_S3 = 2'd2;
  localparam logic [1:0] DIR_S4 = 2'd3;

  function automatic logic [3:0] dir_to_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/emergency_debounce.sv
// Per-approach debouncer: deb rises after DEBOUNCE_CYC consecutive high
// samples and drops on the first low sample.
module emergency_debounce #(
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!raw) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign deb = (cnt == CNT_MAX);

endmodule

// File: rtl/emergency_preempt_arbiter.sv
// Emergency-vehicle preemption arbiter with req/ack handover, hold limits,
// cooldown and round-robin fairness. EMERG_FIXED_PRIO_EN selects S1>S2>S3>S4.
module emergency_preempt_arbiter
  import emergency_preempt_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3,
  parameter int HOLD_MIN     = 8,
  parameter int HOLD_MAX     = 30,
  parameter int COOLDOWN     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency_s1,
  input  logic       emergency_s2,
  input  logic       emergency_s3,
  input  logic       emergency_s4,
  input  logic       ctrl_ack,
  output logic       preempt_req,
  output logic [1:0] preempt_dir,
  output logic [3:0] grant_onehot,
  output logic       preempt_active,
  output logic       timeout_flag
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int CW = $clog2(COOLDOWN) + 1;
  localparam logic [HW-1:0] HOLD_MIN_C = HW'(HOLD_MIN);
  localparam logic [HW-1:0] HOLD_MAX_C = HW'(HOLD_MAX);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN - 1);

  logic [3:0]    raw;
  logic [3:0]    deb;
  logic [3:0]    mask;
  logic [3:0]    elig;
  logic [1:0]    winner;
  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] cool_cnt;

  assign raw  = {emergency_s4, emergency_s3, emergency_s2, emergency_s1};
  assign elig = deb & ~mask;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    emergency_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
      .clk (clk),
      .rst (rst),
      .raw (raw[g]),
      .deb (deb[g])
    );
  end

`ifdef EMERG_FIXED_PRIO_EN
  always_comb begin
    winner = DIR_S1;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) winner = 2'(i);
    end
  end
`else
  logic [1:0] last;

  // Pointer advances to the approach the controller actually acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= DIR_S4;
    end else if (state == ST_REQ && ctrl_ack) begin
      last <= preempt_dir;
    end
  end

  // Later iterations overwrite earlier ones, so last+1 ends up with top priority.
  always_comb begin
    logic [1:0] idx;
    winner = DIR_S1;
    idx    = DIR_S1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (elig[idx]) winner = idx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      preempt_req    <= 1'b0;
      preempt_dir    <= DIR_S1;
      grant_onehot   <= 4'b0000;
      preempt_active <= 1'b0;
      timeout_flag   <= 1'b0;
      hold_cnt       <= '0;
      cool_cnt       <= '0;
      mask           <= 4'b0000;
    end else begin
      timeout_flag <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!raw[i]) mask[i] <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (|elig) begin
            preempt_dir  <= winner;
            grant_onehot <= dir_to_onehot(winner);
            preempt_req  <= 1'b1;
            state        <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (ctrl_ack) begin
            hold_cnt       <= '0;
            preempt_active <= 1'b1;
            state          <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (!ctrl_ack || (hold_cnt >= HOLD_MIN_C && !deb[preempt_dir])) begin
            preempt_req    <= 1'b0;
            preempt_active <= 1'b0;
            grant_onehot   <= 4'b0000;
            state          <= ST_RELEASE;
          end else if (hold_cnt == HOLD_MAX_C) begin
            // Forced release; mask the approach until its sensor is seen low.
            preempt_req    <= 1'b0;
            preempt_active <= 1'b0;
            grant_onehot   <= 4'b0000;
            timeout_flag   <= 1'b1;
            if (raw[preempt_dir]) mask[preempt_dir] <= 1'b1;
            state          <= ST_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        ST_RELEASE: begin
          if (!ctrl_ack) begin
            cool_cnt <= '0;
            state    <= ST_COOLDOWN;
          end
        end

        ST_COOLDOWN: begin
          if (cool_cnt == COOL_LAST) begin
            state <= ST_IDLE;
          end else begin
            cool_cnt <= cool_cnt + CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emergency_preempt_arbiter.sv
// Directed self-checking bench for emergency_preempt_arbiter (default and
// EMERG_FIXED_PRIO_EN builds).
module tb_emergency_preempt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       emergency_s1, emergency_s2, emergency_s3, emergency_s4;
  logic       ctrl_ack;
  logic       preempt_req;
  logic [1:0] preempt_dir;
  logic [3:0] grant_onehot;
  logic       preempt_active;
  logic       timeout_flag;

  int total = 0;
  int bad   = 0;

  emergency_preempt_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .emergency_s1   (emergency_s1),
    .emergency_s2   (emergency_s2),
    .emergency_s3   (emergency_s3),
    .emergency_s4   (emergency_s4),
    .ctrl_ack       (ctrl_ack),
    .preempt_req    (preempt_req),
    .preempt_dir    (preempt_dir),
    .grant_onehot   (grant_onehot),
    .preempt_active (preempt_active),
    .timeout_flag   (timeout_flag)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {emergency_s1, emergency_s2, emergency_s3, emergency_s4} = 4'b0000;
    ctrl_ack = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic level, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (preempt_req === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_ack = 1'b0;
    {emergency_s1, emergency_s2, emergency_s3, emergency_s4} = 4'b1111;
    tick(2);
    total++;
    if ({preempt_req, preempt_dir, grant_onehot, preempt_active, timeout_flag} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_during: got req=%b dir=%0d oh=%b act=%b to=%b, want all 0",
               preempt_req, preempt_dir, grant_onehot, preempt_active, timeout_flag);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({preempt_req, preempt_dir, grant_onehot, preempt_active, timeout_flag} !== 9'b0) begin
      bad++;
      $display("[TB] FAIL reset_after: got req=%b dir=%0d oh=%b act=%b to=%b, want all 0",
               preempt_req, preempt_dir, grant_onehot, preempt_active, timeout_flag);
    end
    {emergency_s1, emergency_s2, emergency_s3, emergency_s4} = 4'b0000;
    tick(3);
  endtask

  task automatic test_single();
    do_reset();
    emergency_s2 = 1'b1;
    tick(3);
    total++;
    if (preempt_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_early: got req=%b, want 0 at edge 3", preempt_req);
    end
    tick();
    total++;
    if ({preempt_req, preempt_dir, grant_onehot} !== {1'b1, 2'd1, 4'b0010}) begin
      bad++;
      $display("[TB] FAIL single_grant: got req=%b dir=%0d oh=%b, want 1/1/0010",
               preempt_req, preempt_dir, grant_onehot);
    end
    tick(2);
    ctrl_ack = 1'b1;
    tick();
    total++;
    if ({preempt_req, preempt_active} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL single_hold: got req=%b act=%b, want 1/1", preempt_req, preempt_active);
    end
    tick(2);
    emergency_s2 = 1'b0;
    tick(6);
    total++;
    if ({preempt_req, preempt_active} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL single_min_hold: got req=%b act=%b at hold 7, want 1/1",
               preempt_req, preempt_active);
    end
    tick();
    total++;
    if ({preempt_req, preempt_active, grant_onehot, timeout_flag} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL single_release: got req=%b act=%b oh=%b to=%b, want all 0",
               preempt_req, preempt_active, grant_onehot, timeout_flag);
    end
    emergency_s2 = 1'b1;
    ctrl_ack = 1'b0;
    tick(5);
    total++;
    if (preempt_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cooldown_block: got req=%b on last cooldown edge, want 0", preempt_req);
    end
    tick();
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd1}) begin
      bad++;
      $display("[TB] FAIL cooldown_regrant: got req=%b dir=%0d, want 1/1", preempt_req, preempt_dir);
    end
    emergency_s2 = 1'b0;
    tick(3);
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd1}) begin
      bad++;
      $display("[TB] FAIL req_withdraw: got req=%b dir=%0d, want locked 1/1", preempt_req, preempt_dir);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    do_reset();
    emergency_s3 = 1'b1;
    tick(2);
    emergency_s3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (preempt_req !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("[TB] FAIL glitch: got req=1 after 2-cycle pulse, want 0");
    end
    emergency_s3 = 1'b1;
    tick(3);
    emergency_s3 = 1'b0;
    tick();
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd2}) begin
      bad++;
      $display("[TB] FAIL exact_pulse: got req=%b dir=%0d, want 1/2", preempt_req, preempt_dir);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [1:0] exp_dir;
    do_reset();
    emergency_s1 = 1'b1;
    emergency_s4 = 1'b1;
    tick(4);
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd0}) begin
      bad++;
      $display("[TB] FAIL fair_first: got req=%b dir=%0d, want 1/0", preempt_req, preempt_dir);
    end
    ctrl_ack = 1'b1;
    tick(11);
    emergency_s1 = 1'b0;
    tick();
    emergency_s1 = 1'b1;
    tick();
    total++;
    if (preempt_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fair_release: got req=%b, want 0", preempt_req);
    end
    ctrl_ack = 1'b0;
    tick(5);
    total++;
    if (preempt_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fair_cooldown: got req=%b, want 0", preempt_req);
    end
    tick();
`ifdef EMERG_FIXED_PRIO_EN
    exp_dir = 2'd0;
`else
    exp_dir = 2'd3;
`endif
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, exp_dir}) begin
      bad++;
      $display("[TB] FAIL fair_second: got req=%b dir=%0d, want 1/%0d", preempt_req, preempt_dir, exp_dir);
    end
`ifndef EMERG_FIXED_PRIO_EN
    ctrl_ack = 1'b1;
    emergency_s4 = 1'b0;
    wait_req(1'b0, 40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("[TB] FAIL fair_s4_release: req still 1 after 40 cycles, want 0");
    end
    ctrl_ack = 1'b0;
    wait_req(1'b1, 40, ok);
    total++;
    if (!ok || preempt_dir !== 2'd0) begin
      bad++;
      $display("[TB] FAIL fair_third: got req=%b dir=%0d, want 1/0", preempt_req, preempt_dir);
    end
`endif
  endtask

  task automatic test_stuck();
    bit seen;
    do_reset();
    emergency_s3 = 1'b1;
    tick(4);
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd2}) begin
      bad++;
      $display("[TB] FAIL stuck_grant: got req=%b dir=%0d, want 1/2", preempt_req, preempt_dir);
    end
    ctrl_ack = 1'b1;
    tick(31);
    total++;
    if ({preempt_req, timeout_flag} !== 2'b10) begin
      bad++;
      $display("[TB] FAIL stuck_hold29: got req=%b to=%b, want 1/0", preempt_req, timeout_flag);
    end
    tick();
    total++;
    if ({preempt_req, preempt_active, timeout_flag} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL stuck_timeout: got req=%b act=%b to=%b, want 0/0/1",
               preempt_req, preempt_active, timeout_flag);
    end
    ctrl_ack = 1'b0;
    tick();
    total++;
    if (timeout_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stuck_pulse: got to=%b one cycle later, want 0", timeout_flag);
    end
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (preempt_req !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("[TB] FAIL stuck_mask: got req=1 while s3 stuck high, want 0");
    end
    emergency_s3 = 1'b0;
    tick();
    emergency_s3 = 1'b1;
    tick(3);
    total++;
    if (preempt_req !== 1'b0) begin
      bad++;
      $display("[TB] FAIL stuck_redebounce: got req=%b before re-debounce, want 0", preempt_req);
    end
    tick();
    total++;
    if ({preempt_req, preempt_dir} !== {1'b1, 2'd2}) begin
      bad++;
      $display("[TB] FAIL stuck_regrant: got req=%b dir=%0d, want 1/2", preempt_req, preempt_dir);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    emergency_s2 = 1'b1;
    tick(4);
    ctrl_ack = 1'b1;
    tick();
    total++;
    if (preempt_active !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrst_hold: got act=%b, want 1", preempt_active);
    end
    rst = 1'b1;
    tick();
    total++;
    if ({preempt_req, preempt_active, grant_onehot} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL midrst_drop: got req=%b act=%b oh=%b, want 0/0/0000",
               preempt_req, preempt_active, grant_onehot);
    end
    rst = 1'b0;
    ctrl_ack = 1'b0;
    emergency_s2 = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [1:0] exp_dir;
    do_reset();
    for (int r = 0; r < 2; r++) begin
`ifdef EMERG_FIXED_PRIO_EN
      exp_dir = 2'd1;
`else
      exp_dir = (r == 0) ? 2'd1 : 2'd3;
`endif
      emergency_s2 = 1'b1;
      emergency_s4 = 1'b1;
      wait_req(1'b1, 40, ok);
      total++;
      if (!ok || preempt_dir !== exp_dir) begin
        bad++;
        $display("[TB] FAIL b2b_round%0d: got req=%b dir=%0d, want 1/%0d",
                 r, preempt_req, preempt_dir, exp_dir);
      end
      ctrl_ack = 1'b1;
      tick();
      emergency_s2 = 1'b0;
      emergency_s4 = 1'b0;
      wait_req(1'b0, 40, ok);
      total++;
      if (!ok) begin
        bad++;
        $display("[TB] FAIL b2b_release%0d: req still 1 after 40 cycles, want 0", r);
      end
      ctrl_ack = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    ctrl_ack = 1'b0;
    {emergency_s1, emergency_s2, emergency_s3, emergency_s4} = 4'b0000;
    test_reset();
    test_single();
    test_glitch();
    test_fairness();
    test_stuck();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/emergency_preempt_arbiter.md
Name: emergency_preempt_arbiter

Overview:
- Arbitrates emergency-vehicle preemption requests from the four approaches (S1..S4) and sequences the handover of the intersection to the traffic-light controller through a four-phase req/ack handshake.
- Sits between the raw emergency_sN inputs and the preemption port of the intersection controller. It guarantees:
  - one preempted approach at a time;
  - a minimum and a maximum hold time;
  - a cooldown between preemptions;
  - round-robin fairness.

Parameters:
- DEBOUNCE_CYC, 3: consecutive high samples required before a request counts as valid (≥1).
- HOLD_MIN, 8: minimum cycles a granted preemption is held after ack (≥1).
- HOLD_MAX, 30: forced-release limit on hold cycles (≥HOLD_MIN).
- COOLDOWN, 4: idle cycles after release before any new grant (≥1).

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous active-high reset
- emergency_s1..emergency_s4  in  1 each  raw emergency request per approach
- ctrl_ack  in  1  controller: all-red clearance done, preempted approach green
- preempt_req  out  1  request for preemption to controller
- preempt_dir  out  2  granted approach (0=S1, 1=S2, 2=S3, 3=S4); valid while preempt_req=1
- grant_onehot  out  4  one-hot of preempt_dir in REQ/HOLD, else 0
- preempt_active  out  1  high while in HOLD
- timeout_flag  out  1  one-cycle pulse on HOLD_MAX forced release

Interface is fixed: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset: all outputs 0; FSM to IDLE; debounce counters, masks and hold/cooldown counters cleared; round-robin pointer set to last=S4, so S1 has top priority first.
- Reset mid-operation: preempt_req drops at the next edge regardless of ctrl_ack.
- Debounce, per input:
  - Saturating counter increments while the input is high and clears when it is low.
  - deb_N=1 when the counter equals DEBOUNCE_CYC; deassertion is immediate.
  - Pulses shorter than DEBOUNCE_CYC cycles are ignored.
- Eligible request: elig_N = deb_N & ~mask_N.
- FSM states: IDLE, REQ, HOLD, RELEASE, COOLDOWN.
  - IDLE: if any elig_N, pick the winner (round-robin, searching from last+1), latch preempt_dir, set preempt_req=1 and go to REQ on the same edge. Latency from the first sampled-high input to preempt_req=1 is DEBOUNCE_CYC+1 edges.
  - REQ: direction is locked; a withdrawn request does not abort. On ctrl_ack=1 go to HOLD, clear hold_cnt and update the pointer last=dir.
  - HOLD: hold_cnt increments each cycle. Go to RELEASE when:
    - (hold_cnt ≥ HOLD_MIN and deb_dir=0), or
    - hold_cnt == HOLD_MAX: also pulse timeout_flag and set mask_dir, or
    - ctrl_ack drops (controller abort).
  - RELEASE: preempt_req=0; wait for ctrl_ack=0, then go to COOLDOWN.
  - COOLDOWN: count COOLDOWN cycles, then go to IDLE. Requests keep debouncing but are not granted.
- mask_N clears when emergency_sN is sampled low, so a stuck sensor cannot monopolise the intersection.
- Simultaneous requests are resolved by round-robin only. A new request arriving during REQ/HOLD waits.
- Widths: hold_cnt is $clog2(HOLD_MAX+1) bits and saturates at HOLD_MAX. Debounce and cooldown counters are sized by $clog2 of their parameter plus 1.

Optional Feature:
- Macro: EMERG_FIXED_PRIO_EN
- Defined: fixed priority S1>S2>S3>S4 replaces round-robin; the pointer is unused.
- Undefined: round-robin as above.
- Masking, timing and the handshake are identical in both builds.

Decomposition:
- Package emergency_preempt_pkg contains:
  - state encoding (IDLE=0 .. COOLDOWN=4);
  - direction constants DIR_S1..DIR_S4;
  - the dir-to-one-hot conversion function.
- Sub-module emergency_debounce (parameter DEBOUNCE_CYC; in clk, rst, raw; out deb): four instances.
- Arbitration and the FSM live in the top module.

Test Plan:
- Reset: rst high 2 cycles with all emergency inputs high → all outputs 0 during rst and at the first edge after it.
- Single request: emergency_s2 high from edge 0 → preempt_req=1, preempt_dir=1, grant_onehot=4'b0010 at edge 4.
  - ctrl_ack at edge 6 → preempt_active=1 from edge 7.
  - s2 low at edge 9 → release when hold_cnt=8, then ack low, 4 cooldown cycles, then IDLE.
- Glitch: emergency_s3 high for 2 cycles → preempt_req stays 0.
- Fairness: s1 and s4 rise on the same edge → S1 (dir 0) granted first.
  - s1 drops after 10 hold cycles, then reasserts.
  - After cooldown, S4 (dir 3) is granted, not S1.
- Stuck sensor: s3 held high 100 cycles → forced release at hold_cnt=30 with one timeout_flag pulse.
  - No re-grant of S3 until s3 goes low ≥1 cycle and re-debounces.
- Mid-operation reset and build option:
  - rst during HOLD → preempt_req=0 and preempt_active=0 at the next edge.
  - With EMERG_FIXED_PRIO_EN defined, simultaneous s2/s4 → S2 granted on every repeat.
